dmem_arbiter: RTL

Two-requester arbiter and sequencer for the single data-memory port (`memread`/`memwrite`/`sign_mask` interface). Port 0 is the core load/store unit. Port 1 is the secondary master (debug/DMA). It serialises accesses, issues one single-cycle strobe per transaction, waits the fixed memory read latency, and returns a one-cycle acknowledge with registered read data to the winning requester.

---
 rtl/dmem_arbiter_if.sv | 66 ++++++
 rtl/dmem_arbiter.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter_if.sv
// ---------------------------------------------------------------------------
// dmem_arbiter_if
// Bundle of the two requester ports and the single data-memory port that
// dmem_arbiter sits between.
//   m0_* / m1_*   : requester side (req, we, addr, wdata, sign_mask in;
//                   ack, rdata out of the arbiter)
//   mem_*         : memory side (addr, write_data, sign_mask, memread,
//                   memwrite out of the arbiter; read_data in)
//   busy          : arbiter is somewhere other than IDLE
// Modports:
//   slave  : the arbiter's view
//   master : the view of whatever drives the requests and models memory
//
// Handshake: a requester raises req with we/addr/wdata/sign_mask stable and
// keeps them stable until its ack pulses for one cycle. Dropping req before
// ack does not cancel the transaction. The memory sees exactly one
// single-cycle memread or memwrite strobe per transaction and must present
// read_data a fixed RD_LAT cycles after the memread strobe cycle.
// ---------------------------------------------------------------------------
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic [3:0]        m0_sign_mask;
  logic              m0_ack;
  logic [DATA_W-1:0] m0_rdata;

  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic [3:0]        m1_sign_mask;
  logic              m1_ack;
  logic [DATA_W-1:0] m1_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_write_data;
  logic [3:0]        mem_sign_mask;
  logic              mem_memread;
  logic              mem_memwrite;
  logic [DATA_W-1:0] mem_read_data;

  logic              busy;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata, m0_sign_mask,
    input  m1_req, m1_we, m1_addr, m1_wdata, m1_sign_mask,
    input  mem_read_data,
    output m0_ack, m0_rdata, m1_ack, m1_rdata,
    output mem_addr, mem_write_data, mem_sign_mask, mem_memread, mem_memwrite,
    output busy
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata, m0_sign_mask,
    output m1_req, m1_we, m1_addr, m1_wdata, m1_sign_mask,
    output mem_read_data,
    input  m0_ack, m0_rdata, m1_ack, m1_rdata,
    input  mem_addr, mem_write_data, mem_sign_mask, mem_memread, mem_memwrite,
    input  busy
  );
endinterface

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
// Two-requester arbiter/sequencer for the single data-memory port.
// Port 0 is the core load/store unit, port 1 the secondary master.
// Each transaction: IDLE (arbitrate, latch winner) -> ISSUE (one strobe)
// -> WAIT (loads only, RD_LAT cycles of memory latency) -> RESP (one-cycle
// ack to the winner). Load data is registered into the winner's rdata.
//
// Parameters: ADDR_W, DATA_W, RD_LAT (memory read latency, 1..15).
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus         : dmem_arbiter_if.slave (requester and memory signals)
//   dbg_state   : current FSM state (0 IDLE, 1 ISSUE, 2 WAIT, 3 RESP)
//
// Build option: define DMEM_ARB_ROUND_ROBIN_EN to break ties in favour of
// the port not granted last; otherwise port 0 always wins a tie.
// ---------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  dmem_arbiter_if.slave   bus,
  output logic [1:0]      dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // RD_LAT is limited to 1..15 so the 4-bit counter never wraps.
  localparam logic [3:0] CNT_INIT = 4'(RD_LAT - 1);

  state_t            state_q, state_d;
  logic              gnt_q;      // port owning the current/last transaction
  logic              we_q;       // latched direction of the current transaction
  logic [3:0]        cnt_q;      // read-latency countdown
  logic              mask_q;     // high in the IDLE cycle right after RESP
  logic              busy_q;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
  logic              last_q;     // port granted most recently
`endif

  logic              req0_eff, req1_eff;
  logic              win;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [3:0]        sel_mask;

  assign dbg_state = state_q;
  assign bus.busy  = busy_q;

  // Arbitration and next state. The just-served port is ignored for one
  // IDLE cycle so a requester that drops req a cycle after ack is not
  // served twice.
  always_comb begin
    req0_eff = bus.m0_req && !(mask_q && !gnt_q);
    req1_eff = bus.m1_req && !(mask_q &&  gnt_q);
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    win = req1_eff && (!req0_eff || !last_q);
`else
    win = req1_eff && !req0_eff;
`endif
    sel_we    = win ? bus.m1_we        : bus.m0_we;
    sel_addr  = win ? bus.m1_addr      : bus.m0_addr;
    sel_wdata = win ? bus.m1_wdata     : bus.m0_wdata;
    sel_mask  = win ? bus.m1_sign_mask : bus.m0_sign_mask;

    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req0_eff || req1_eff) state_d = ISSUE;
      ISSUE:   state_d = we_q ? RESP : WAIT;
      WAIT:    if (cnt_q == 4'd0) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q            <= IDLE;
      gnt_q              <= 1'b0;
      we_q               <= 1'b0;
      cnt_q              <= 4'd0;
      mask_q             <= 1'b0;
      busy_q             <= 1'b0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      last_q             <= 1'b1;
`endif
      bus.mem_addr       <= '0;
      bus.mem_write_data <= '0;
      bus.mem_sign_mask  <= '0;
      bus.mem_memread    <= 1'b0;
      bus.mem_memwrite   <= 1'b0;
      bus.m0_ack         <= 1'b0;
      bus.m1_ack         <= 1'b0;
      bus.m0_rdata       <= '0;
      bus.m1_rdata       <= '0;
    end else begin
      state_q          <= state_d;
      mask_q           <= (state_q == RESP);
      busy_q           <= (state_d != IDLE);
      // Strobes and acks are single-cycle: default low, set below.
      bus.mem_memread  <= 1'b0;
      bus.mem_memwrite <= 1'b0;
      bus.m0_ack       <= 1'b0;
      bus.m1_ack       <= 1'b0;

      unique case (state_q)
        IDLE: begin
          if (state_d == ISSUE) begin
            gnt_q              <= win;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            last_q             <= win;
`endif
            we_q               <= sel_we;
            bus.mem_addr       <= sel_addr;
            bus.mem_write_data <= sel_wdata;
            bus.mem_sign_mask  <= sel_mask;
            bus.mem_memread    <= !sel_we;
            bus.mem_memwrite   <= sel_we;
          end
        end
        ISSUE: begin
          cnt_q <= CNT_INIT;
          // A store completes straight away: ack lands in RESP.
          if (we_q) begin
            bus.m0_ack <= !gnt_q;
            bus.m1_ack <=  gnt_q;
          end
        end
        WAIT: begin
          if (cnt_q == 4'd0) begin
            if (gnt_q) bus.m1_rdata <= bus.mem_read_data;
            else       bus.m0_rdata <= bus.mem_read_data;
            bus.m0_ack <= !gnt_q;
            bus.m1_ack <=  gnt_q;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
        end
        default: begin
        end
      endcase
    end
  end

endmodule
